// File: rtl/gray_counter_pkg.sv
// Shared constants and the binary-to-Gray conversion used across the Gray counter.
package gray_counter_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 8;
  localparam int GRAY_MAX_WIDTH     = 64;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational WIDTH-bit binary-to-Gray encoder; zero latency, no flow control.
module gray_enc
  import gray_counter_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  // Widen into the package function, then keep only the live bits.
  assign gray_o = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_i)));

endmodule

// File: rtl/gray_counter.sv
// Gray-coded up counter with a registered one-cycle wrap pulse; 1-cycle latency, no backpressure.
// Defining GRAY_COUNTER_BIN_OUT_EN adds count_bin, the registered binary count aligned with count.
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             count_clr,
  output logic [WIDTH-1:0] count,
  output logic             overflow
`ifdef GRAY_COUNTER_BIN_OUT_EN
  ,
  output logic [WIDTH-1:0] count_bin
`endif
);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;

  // Clear beats enable; the wrap pulse only fires on an incrementing edge.
  always_comb begin
    bin_d = bin_q;
    ovf_d = 1'b0;
    if (count_clr) begin
      bin_d = '0;
    end else if (count_en) begin
      bin_d = bin_q + WIDTH'(1'b1);
      ovf_d = &bin_q;
    end
  end

  gray_enc #(
    .WIDTH (WIDTH)
  ) u_gray_enc (
    .bin_i  (bin_d),
    .gray_o (count_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count    = count_q;
  assign overflow = ovf_q;
`ifdef GRAY_COUNTER_BIN_OUT_EN
  assign count_bin = bin_q;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed sequences plus random traffic against a count model.
module tb_gray_counter;
  localparam int W = 8;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         count_en = 1'b0;
  logic         count_clr = 1'b0;
  logic [W-1:0] count;
  logic         overflow;
`ifdef GRAY_COUNTER_BIN_OUT_EN
  logic [W-1:0] count_bin;
`endif

  int errors = 0;
  int checks = 0;

  // Model: a plain integer step count and the wrap flag it implies.
  int m_n   = 0;
  bit m_ovf = 1'b0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_en  (count_en),
    .count_clr (count_clr),
    .count     (count),
    .overflow  (overflow)
`ifdef GRAY_COUNTER_BIN_OUT_EN
    ,
    .count_bin (count_bin)
`endif
  );

  function automatic logic [W-1:0] gray_of(input int n);
    int g;
    g = n ^ (n / 2);
    return W'(g);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, advance the model, compare after the edge.
  task automatic step(input bit r, input bit c, input bit e);
    logic [W-1:0] prev;
    bit moved;
    prev      = count;
    rst       = r;
    count_clr = c;
    count_en  = e;
    moved     = 1'b0;
    @(posedge clk);
    if (r || c) begin
      m_n   = 0;
      m_ovf = 1'b0;
    end else if (e) begin
      m_ovf = (m_n == MOD - 1);
      m_n   = (m_n + 1) % MOD;
      moved = 1'b1;
    end else begin
      m_ovf = 1'b0;
    end
    #1;
    check("count", 32'(count), 32'(gray_of(m_n)));
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef GRAY_COUNTER_BIN_OUT_EN
    check("count_bin", 32'(count_bin), 32'(m_n));
`endif
    if (moved && !$isunknown(prev))
      check("onebit", 32'($countones(prev ^ count)), 32'd1);
  endtask

  logic [W-1:0] exp_a [5];
  logic [W-1:0] exp_b [3];

  initial begin
    exp_a = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07};
    exp_b = '{8'h05, 8'h04, 8'h0C};

    @(posedge clk); #1;

    // Reset with enable held high, then idle after release.
    step(1, 0, 1);
    step(1, 0, 1);
    check("rst_count", 32'(count), 32'h00);
    check("rst_ovf", 32'(overflow), 32'd0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("rst_idle", 32'(count), 32'h00);

    // Enable / hold pattern.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1);
      check("en_seq_a", 32'(count), 32'(exp_a[i]));
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      check("hold_07", 32'(count), 32'h07);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      check("en_seq_b", 32'(count), 32'(exp_b[i]));
    end

    // Clear beats enable, then holds at zero.
    step(0, 1, 1);
    check("clr_count", 32'(count), 32'h00);
    check("clr_ovf", 32'(overflow), 32'd0);
    step(0, 0, 0);
    check("clr_hold", 32'(count), 32'h00);

    // Reset raised mid-count must not move outputs before the edge.
    step(0, 0, 1);
    step(0, 0, 1);
    rst = 1'b1;
    #2;
    check("rst_sync", 32'(count), 32'(gray_of(m_n)));
    step(1, 0, 0);
    check("rst_mid", 32'(count), 32'h00);

    // Full wrap from reset.
    step(1, 0, 0);
    for (int s = 1; s <= 257; s++) begin
      step(0, 0, 1);
      if (s == 1) check("first_01", 32'(count), 32'h01);
      if (s == 255) begin
        check("wrap_80", 32'(count), 32'h80);
        check("wrap_80_ovf", 32'(overflow), 32'd0);
      end
      if (s == 256) begin
        check("wrap_00", 32'(count), 32'h00);
        check("wrap_ovf", 32'(overflow), 32'd1);
      end
      if (s == 257) check("wrap_ovf_gone", 32'(overflow), 32'd0);
    end

    // Everything at once, then stall exactly at 0x80.
    step(1, 1, 1);
    check("all_count", 32'(count), 32'h00);
    check("all_ovf", 32'(overflow), 32'd0);
    for (int s = 0; s < 255; s++) step(0, 0, 1);
    check("stall_80", 32'(count), 32'h80);
    for (int s = 0; s < 3; s++) begin
      step(0, 0, 0);
      check("stall_no_ovf", 32'(overflow), 32'd0);
    end
    step(0, 0, 1);
    check("resume_ovf", 32'(overflow), 32'd1);
    step(0, 0, 0);
    check("hold0_no_ovf", 32'(overflow), 32'd0);

    // Random traffic with rare resets and clears.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits (minimum 2).
REQ-002 The block SHALL have input clk, 1 bit, as the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have input rst, 1 bit, a synchronous, active-high reset.
REQ-004 The block SHALL have input count_en, 1 bit, which advances the count by one step per cycle while high.
REQ-005 The block SHALL have input count_clr, 1 bit, a synchronous clear of count and overflow.
REQ-006 The block SHALL have output count, WIDTH bits, the registered Gray-coded count.
REQ-007 The block SHALL have output overflow, 1 bit, a registered one-cycle wrap pulse.

Function
REQ-008 The block SHALL hold an internal WIDTH-bit binary counter bin; count SHALL always equal bin ^ (bin >> 1), registered with no combinational path from any input.
REQ-009 Priority on each clk edge SHALL be: rst > count_clr > count_en > hold.
REQ-010 If count_clr=1 (rst=0), bin and count SHALL become 0 and overflow 0 on that edge, regardless of count_en.
REQ-011 If count_en=1 (rst=0, count_clr=0), bin SHALL increment by 1 modulo 2^WIDTH; count SHALL show the new Gray value on the same edge (latency 1 cycle).
REQ-012 If count_en=0 (rst=0, count_clr=0), bin and count SHALL hold; overflow SHALL be 0.
REQ-013 Successive count values SHALL differ in exactly one bit, including the wrap step.
REQ-014 Wrap: an increment from bin=2^WIDTH-1 (count=0x80 for WIDTH=8) to bin=0 SHALL set overflow=1 for exactly the one cycle in which count=0.
REQ-015 overflow SHALL be 0 in every other cycle, including while count=0x80 and whenever count holds at 0 because count_en=0.
REQ-016 count_en deasserted on the wrap cycle SHALL NOT produce an overflow pulse; the pulse is generated only on the incrementing edge.

Reset
REQ-017 When rst=1 at a clk edge, bin, count and overflow SHALL all become 0, regardless of count_en and count_clr.
REQ-018 The first edge with rst=0 and count_en=1 after reset SHALL produce count=0x01.
REQ-019 Reset asserted mid-count SHALL take effect on the next clk edge only; outputs SHALL NOT change asynchronously.

Configuration
REQ-020 Macro GRAY_COUNTER_BIN_OUT_EN, when defined, SHALL add output count_bin (WIDTH bits) carrying the registered internal binary value bin, aligned with count.
REQ-021 Without GRAY_COUNTER_BIN_OUT_EN, port count_bin SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-022 A shared package gray_counter_pkg SHALL hold the default width constant (8) and a bin-to-Gray conversion function.
REQ-023 One sub-module, gray_enc (combinational WIDTH-bit binary-to-Gray encoder), SHALL produce the next Gray value that feeds the count register.

Verification
REQ-024 Reset: rst=1 for 2 cycles with count_en=1 -> count=0x00, overflow=0; release with count_en=0 for 2 cycles -> count stays 0x00.
REQ-025 Enable/hold: count_en=1 for 5 cycles -> count 01,03,02,06,07; count_en=0 for 3 cycles -> holds 07; count_en=1 for 3 cycles -> 05,04,0C.
REQ-026 Clear priority: count_clr=1 with count_en=1 at count=0x0C -> next edge count=0x00, overflow=0; count_clr=0, count_en=0 -> holds 0x00.
REQ-027 Full sequence: from reset, 256 enabled cycles -> count equals bin2gray(n) at every step, one-bit change per step, count=0x80 at step 255 with overflow=0, count=0x00 with overflow=1 at step 256, overflow=0 at step 257.
REQ-028 Simultaneous events: rst=1 and count_clr=1 and count_en=1 on one edge -> count=0x00, overflow=0; count_en dropped exactly at count=0x80 -> no overflow pulse.
